// File: rtl/mc_ctrl_unit_hs.sv
// Multicycle CPU control unit with a memory req/ready handshake, wait-state timeout, halt and illegal-opcode trap.
// Define MOVCOND_EN to decode movn/movz; when it is undefined, those encodings trap as illegal.
module mc_ctrl_unit_hs #(
    parameter int         ALUOP_W     = 4,
    parameter int         MEM_TIMEOUT = 15,
    parameter logic [5:0] HALT_OP     = 6'b111111
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic [5:0]         op_instruction,
    input  logic [5:0]         func_instruction,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               ir_we,
    output logic               w_pc,
    output logic               slc_ALUA,
    output logic               slc_ALUB,
    output logic [1:0]         slc_RFWriteData,
    output logic               w_RF,
    output logic [1:0]         op_ext,
    output logic [1:0]         slc_pcSrc,
    output logic [1:0]         slc_RFWriteAddr,
    output logic [ALUOP_W-1:0] op_ALU,
    output logic               halted,
    output logic               illegal,
    output logic               bus_err,
    output logic [2:0]         state_o
);

    typedef enum logic [2:0] {
        S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3,
        S_WB = 3'd4, S_HALT = 3'd5, S_ERR = 3'd6
    } state_t;

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_LIMIT = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;

    state_t state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic halted_q, halted_d, illegal_q, illegal_d, bus_err_q, bus_err_d;

    logic is_r, is_add, is_sub, is_slt, is_and, is_or, is_sll, is_jr, is_movz, is_movn, is_mov;
    logic is_addi, is_ori, is_lw, is_sw, is_beq, is_j, is_jal, is_halt, legal, use_imm, timeout;
    logic [3:0] alu_code;
    logic [1:0] ext_code;

    assign is_r    = (op_instruction == 6'b000000);
    assign is_add  = is_r && (func_instruction == 6'b100000);
    assign is_sub  = is_r && (func_instruction == 6'b100010);
    assign is_slt  = is_r && (func_instruction == 6'b101010);
    assign is_and  = is_r && (func_instruction == 6'b100100);
    assign is_or   = is_r && (func_instruction == 6'b100101);
    assign is_sll  = is_r && (func_instruction == 6'b000000);
    assign is_jr   = is_r && (func_instruction == 6'b001000);
`ifdef MOVCOND_EN
    assign is_movz = is_r && (func_instruction == 6'b001010);
    assign is_movn = is_r && (func_instruction == 6'b001011);
`else
    assign is_movz = 1'b0;
    assign is_movn = 1'b0;
`endif
    assign is_mov  = is_movz || is_movn;
    assign is_addi = (op_instruction == 6'b001000);
    assign is_ori  = (op_instruction == 6'b001101);
    assign is_lw   = (op_instruction == 6'b100011);
    assign is_sw   = (op_instruction == 6'b101011);
    assign is_beq  = (op_instruction == 6'b000100);
    assign is_j    = (op_instruction == 6'b000010);
    assign is_jal  = (op_instruction == 6'b000011);
    assign is_halt = (op_instruction == HALT_OP);

    assign legal = is_add || is_sub || is_slt || is_and || is_or || is_sll || is_jr || is_mov ||
                   is_addi || is_ori || is_lw || is_sw || is_beq || is_j || is_jal;
    assign use_imm = is_addi || is_ori || is_sll || is_lw || is_sw;

    // Error fires on the MEM_TIMEOUT-th consecutive low cycle; a ready on that cycle still wins.
    assign timeout = (MEM_TIMEOUT != 0) && !mem_ready && (wait_q == WAIT_LIMIT);

    always_comb begin
        alu_code = 4'b0000;
        if (is_sub || is_beq)     alu_code = 4'b0001;
        else if (is_slt)          alu_code = 4'b0010;
        else if (is_sll)          alu_code = 4'b0100;
        else if (is_or || is_ori) alu_code = 4'b0101;
        else if (is_and)          alu_code = 4'b0110;
        else if (is_mov)          alu_code = 4'b1000;
        else if (is_jal)          alu_code = 4'b1001;

        ext_code = 2'b00;
        if (is_lw || is_sw || is_addi || is_beq) ext_code = 2'b10;
        else if (is_ori)                         ext_code = 2'b01;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q   <= S_IF;
            wait_q    <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        wait_d          = '0;
        halted_d        = halted_q;
        illegal_d       = illegal_q;
        bus_err_d       = bus_err_q;
        mem_req         = 1'b0;
        mem_we          = 1'b0;
        ir_we           = 1'b0;
        w_pc            = 1'b0;
        slc_ALUA        = 1'b0;
        slc_ALUB        = 1'b0;
        slc_RFWriteData = 2'b00;
        w_RF            = 1'b0;
        op_ext          = 2'b00;
        slc_pcSrc       = 2'b00;
        slc_RFWriteAddr = 2'b00;
        op_ALU          = '0;

        if ((state_q == S_IF || state_q == S_MEM) && !mem_ready && !timeout)
            wait_d = wait_q + 1'b1;

        unique case (state_q)
            S_IF: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
                if (mem_ready) state_d = S_ID;
                else if (timeout) begin
                    state_d   = S_ERR;
                    bus_err_d = 1'b1;
                    halted_d  = 1'b1;
                end
            end
            S_ID: begin
                op_ext = ext_code;
                if (is_halt) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else if (!legal) begin
                    state_d   = S_HALT;
                    halted_d  = 1'b1;
                    illegal_d = 1'b1;
                end else state_d = S_EX;
            end
            S_EX, S_MEM: begin
                op_ext   = ext_code;
                op_ALU   = ALUOP_W'(alu_code);
                slc_ALUA = !is_jal;
                slc_ALUB = use_imm;
                if (state_q == S_EX) begin
                    if (is_j || is_jr || is_beq) begin
                        w_pc      = 1'b1;
                        slc_pcSrc = is_j ? 2'b11 : is_jr ? 2'b10 : (zero ? 2'b01 : 2'b00);
                        state_d   = S_IF;
                    end else if (is_lw || is_sw) state_d = S_MEM;
                    else state_d = S_WB;
                end else begin
                    mem_req = 1'b1;
                    mem_we  = is_sw;
                    if (mem_ready) begin
                        w_pc    = is_sw;
                        state_d = is_sw ? S_IF : S_WB;
                    end else if (timeout) begin
                        state_d   = S_ERR;
                        bus_err_d = 1'b1;
                        halted_d  = 1'b1;
                    end
                end
            end
            S_WB: begin
                w_pc            = 1'b1;
                slc_pcSrc       = is_jal ? 2'b11 : 2'b00;
                slc_RFWriteData = is_lw ? 2'b01 : (is_mov ? 2'b10 : 2'b00);
                slc_RFWriteAddr = is_jal ? 2'b00 : ((is_addi || is_ori || is_lw) ? 2'b01 :
                                                    (is_r ? 2'b10 : 2'b00));
                w_RF            = !((is_movn && zero) || (is_movz && !zero));
                state_d         = S_IF;
            end
            S_HALT, S_ERR: ;
            default: state_d = S_IF;
        endcase

        // The request must vanish the instant reset asserts, not at the next edge.
        mem_req = mem_req && !reset;
    end

    assign halted  = halted_q;
    assign illegal = illegal_q;
    assign bus_err = bus_err_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_mc_ctrl_unit_hs.sv
// Bench for mc_ctrl_unit_hs: directed vector table, corner sequences and random instruction streams vs a phase-list model.
module tb_mc_ctrl_unit_hs;
    localparam int TO = 4;
    localparam int ST_IF = 0, ST_ID = 1, ST_EX = 2, ST_MEM = 3, ST_WB = 4, ST_HALT = 5, ST_ERR = 6;
    localparam int K_ALU = 0, K_JAL = 1, K_J = 2, K_JR = 3, K_BR = 4, K_LW = 5, K_SW = 6;
    localparam logic [24:0] RST_VEC = 25'h1000000;

    logic CLK = 1'b0, reset, zero, mem_ready;
    logic [5:0] op_instruction, func_instruction;
    logic mem_req, mem_we, ir_we, w_pc, slc_ALUA, slc_ALUB, w_RF, halted, illegal, bus_err;
    logic [1:0] slc_RFWriteData, op_ext, slc_pcSrc, slc_RFWriteAddr;
    logic [3:0] op_ALU;
    logic [2:0] state_o;

    always #5 CLK = ~CLK;

    mc_ctrl_unit_hs #(.ALUOP_W(4), .MEM_TIMEOUT(TO), .HALT_OP(6'b111111)) dut (
        .CLK(CLK), .reset(reset), .op_instruction(op_instruction), .func_instruction(func_instruction),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we),
        .w_pc(w_pc), .slc_ALUA(slc_ALUA), .slc_ALUB(slc_ALUB), .slc_RFWriteData(slc_RFWriteData),
        .w_RF(w_RF), .op_ext(op_ext), .slc_pcSrc(slc_pcSrc), .slc_RFWriteAddr(slc_RFWriteAddr),
        .op_ALU(op_ALU), .halted(halted), .illegal(illegal), .bus_err(bus_err), .state_o(state_o));

    typedef struct {
        bit legal; bit halt; int kind; logic [3:0] alu; bit alua; bit alub;
        logic [1:0] ext; logic [1:0] wdata; logic [1:0] waddr; bit movn; bit movz;
    } info_t;
    typedef struct { int ph; bit rdy; } step_t;
    typedef struct {
        string name; logic [5:0] op; logic [5:0] func; bit z; int ifw; int memw;
        int cyc; int term; bit hl; bit il; bit be;
    } vec_t;

    int checks = 0, failures = 0;
    bit exp_h, exp_i, exp_b;
    step_t seq[$];
    vec_t tbl[$];
    logic [11:0] pool [18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Instruction attributes straight from the decode table; movn/movz trap in the default build.
    function automatic info_t decode(logic [5:0] op, logic [5:0] func);
        info_t d;
        d = '{default: 0};
        d.legal = 1; d.kind = K_ALU; d.alua = 1; d.waddr = 2'b01;
        if (op == 6'h3f) begin d.halt = 1; return d; end
        case (op)
            6'h00: begin
                d.waddr = 2'b10;
                case (func)
                    6'h20: ;
                    6'h22: d.alu = 4'd1;
                    6'h2a: d.alu = 4'd2;
                    6'h24: d.alu = 4'd6;
                    6'h25: d.alu = 4'd5;
                    6'h00: begin d.alu = 4'd4; d.alub = 1; end
                    6'h08: d.kind = K_JR;
                    default: d.legal = 0;
                endcase
            end
            6'h08: begin d.alub = 1; d.ext = 2'b10; end
            6'h0d: begin d.alu = 4'd5; d.alub = 1; d.ext = 2'b01; end
            6'h23: begin d.kind = K_LW; d.alub = 1; d.ext = 2'b10; d.wdata = 2'b01; end
            6'h2b: begin d.kind = K_SW; d.alub = 1; d.ext = 2'b10; end
            6'h04: begin d.kind = K_BR; d.alu = 4'd1; d.ext = 2'b10; end
            6'h02: d.kind = K_J;
            6'h03: begin d.kind = K_JAL; d.alu = 4'd9; d.alua = 0; d.waddr = 2'b00; end
            default: d.legal = 0;
        endcase
        return d;
    endfunction

    function automatic logic [24:0] exp_vec(int ph, info_t d, bit z, bit rdy);
        logic mreq, mwe, irwe, wpc, a, b, wrf;
        logic [1:0] wd, ext, pc, wa;
        logic [3:0] alu;
        {mreq, mwe, irwe, wpc, a, b, wrf, wd, ext, pc, wa, alu} = '0;
        case (ph)
            ST_IF: begin mreq = 1; irwe = rdy; end
            ST_ID: ext = d.ext;
            ST_EX, ST_MEM: begin
                ext = d.ext; alu = d.alu; a = d.alua; b = d.alub;
                if (ph == ST_EX) begin
                    if (d.kind == K_J) begin wpc = 1; pc = 2'b11; end
                    else if (d.kind == K_JR) begin wpc = 1; pc = 2'b10; end
                    else if (d.kind == K_BR) begin wpc = 1; pc = z ? 2'b01 : 2'b00; end
                end else begin
                    mreq = 1; mwe = (d.kind == K_SW); wpc = (d.kind == K_SW) && rdy;
                end
            end
            ST_WB: begin
                wpc = 1; pc = (d.kind == K_JAL) ? 2'b11 : 2'b00;
                wd = d.wdata; wa = d.waddr;
                wrf = !((d.movn && z) || (d.movz && !z));
            end
            default: ;
        endcase
        return {mreq, mwe, irwe, wpc, a, b, wd, wrf, ext, pc, wa, alu, exp_h, exp_i, exp_b, 3'(ph)};
    endfunction

    function automatic logic [24:0] dut_vec();
        return {mem_req, mem_we, ir_we, w_pc, slc_ALUA, slc_ALUB, slc_RFWriteData, w_RF, op_ext,
                slc_pcSrc, slc_RFWriteAddr, op_ALU, halted, illegal, bus_err, state_o};
    endfunction

    task automatic push_mem(input int ph, input int w, output bit err);
        err = 0;
        if (w >= TO) begin
            repeat (TO) seq.push_back('{ph, 1'b0});
            err = 1;
        end else begin
            repeat (w) seq.push_back('{ph, 1'b0});
            seq.push_back('{ph, 1'b1});
        end
    endtask

    // Phase list for one instruction: which phases it visits and how long the memory phases stretch.
    task automatic build(input info_t d, input int ifw, input int memw, output int term);
        bit e;
        seq.delete();
        push_mem(ST_IF, ifw, e);
        if (e) begin term = ST_ERR; return; end
        seq.push_back('{ST_ID, 1'b1});
        if (d.halt || !d.legal) begin term = ST_HALT; return; end
        seq.push_back('{ST_EX, 1'b1});
        term = ST_IF;
        if (d.kind == K_J || d.kind == K_JR || d.kind == K_BR) return;
        if (d.kind == K_LW || d.kind == K_SW) begin
            push_mem(ST_MEM, memw, e);
            if (e) begin term = ST_ERR; return; end
            if (d.kind == K_SW) return;
        end
        seq.push_back('{ST_WB, 1'b1});
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] func, input bit z,
                             input int ifw, input int memw, output int dcyc, output int term);
        info_t d;
        bit left;
        int n;
        d = decode(op, func);
        build(d, ifw, memw, term);
        op_instruction = op; func_instruction = func; zero = z;
        dcyc = 0; left = 0; n = 0;
        foreach (seq[k]) begin
            if (seq[k].ph == ST_IF || seq[k].ph == ST_MEM) mem_ready = seq[k].rdy;
            else mem_ready = 1'($urandom);
            @(negedge CLK);
            chk($sformatf("out op=%h fn=%h c%0d ph%0d", op, func, k, seq[k].ph), 32'(dut_vec()),
                32'(exp_vec(seq[k].ph, d, z, seq[k].rdy)));
            @(posedge CLK); #1;
            n++;
            if (state_o != 3'(ST_IF)) left = 1;
            if (dcyc == 0 && ((left && state_o == 3'(ST_IF)) || state_o >= 3'(ST_HALT))) dcyc = n;
        end
        if (term == ST_HALT) begin exp_h = 1; exp_i = !d.legal; end
        if (term == ST_ERR) begin exp_h = 1; exp_b = 1; end
        chk($sformatf("term_state op=%h", op), 32'(state_o), 32'(term));
        if (term != ST_IF) begin
            repeat (2) begin
                mem_ready = 1'($urandom);
                @(negedge CLK);
                chk("halt_hold", 32'(dut_vec()), 32'({21'b0, exp_h, exp_i, exp_b, 3'(term)}));
                @(posedge CLK); #1;
            end
        end
    endtask

    task automatic do_reset();
        mem_ready = 1'b1;
        reset = 1'b1;
        #1;
        chk("rst_mem_req_drop", 32'(mem_req), 32'd0);
        chk("rst_state_async", 32'(state_o), 32'(ST_IF));
        @(posedge CLK); #1;
        mem_ready = 1'b0;
        reset = 1'b0;
        exp_h = 0; exp_i = 0; exp_b = 0;
        #1;
        chk("post_rst_vec", 32'(dut_vec()), 32'(RST_VEC));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, tm;
        reset = 1; mem_ready = 0; zero = 0; op_instruction = '0; func_instruction = '0;
        exp_h = 0; exp_i = 0; exp_b = 0;
        repeat (2) @(posedge CLK);
        #1 reset = 0;
        #1 chk("reset_vec", 32'(dut_vec()), 32'(RST_VEC));
        // Reset in the middle of a fetch must kill mem_req combinationally.
        reset = 1;
        #1 chk("midfetch_mem_req", 32'(mem_req), 32'd0);
        @(posedge CLK); #1 reset = 0;
        #1 chk("reset_vec2", 32'(dut_vec()), 32'(RST_VEC));

        tbl.push_back('{"add",    6'h00, 6'h20, 0, 0, 0, 4, ST_IF,   0, 0, 0});
        tbl.push_back('{"sub",    6'h00, 6'h22, 1, 0, 0, 4, ST_IF,   0, 0, 0});
        tbl.push_back('{"slt",    6'h00, 6'h2a, 0, 0, 0, 4, ST_IF,   0, 0, 0});
        tbl.push_back('{"and",    6'h00, 6'h24, 0, 0, 0, 4, ST_IF,   0, 0, 0});
        tbl.push_back('{"or",     6'h00, 6'h25, 0, 0, 0, 4, ST_IF,   0, 0, 0});
        tbl.push_back('{"sll",    6'h00, 6'h00, 0, 0, 0, 4, ST_IF,   0, 0, 0});
        tbl.push_back('{"jr",     6'h00, 6'h08, 0, 0, 0, 3, ST_IF,   0, 0, 0});
        tbl.push_back('{"addi",   6'h08, 6'h15, 0, 0, 0, 4, ST_IF,   0, 0, 0});
        tbl.push_back('{"ori",    6'h0d, 6'h2a, 0, 0, 0, 4, ST_IF,   0, 0, 0});
        tbl.push_back('{"lw_w3",  6'h23, 6'h00, 0, 0, 3, 8, ST_IF,   0, 0, 0});
        tbl.push_back('{"sw_if2", 6'h2b, 6'h00, 0, 2, 0, 6, ST_IF,   0, 0, 0});
        tbl.push_back('{"beq_z1", 6'h04, 6'h00, 1, 0, 0, 3, ST_IF,   0, 0, 0});
        tbl.push_back('{"beq_z0", 6'h04, 6'h00, 0, 0, 0, 3, ST_IF,   0, 0, 0});
        tbl.push_back('{"j",      6'h02, 6'h11, 0, 0, 0, 3, ST_IF,   0, 0, 0});
        tbl.push_back('{"jal",    6'h03, 6'h00, 1, 0, 0, 4, ST_IF,   0, 0, 0});
        tbl.push_back('{"add_lim",6'h00, 6'h20, 0, 3, 0, 7, ST_IF,   0, 0, 0});
        tbl.push_back('{"halt",   6'h3f, 6'h00, 0, 0, 0, 2, ST_HALT, 1, 0, 0});
        tbl.push_back('{"op30",   6'h30, 6'h00, 0, 0, 0, 2, ST_HALT, 1, 1, 0});
        tbl.push_back('{"movz",   6'h00, 6'h0a, 0, 0, 0, 2, ST_HALT, 1, 1, 0});
        tbl.push_back('{"movn",   6'h00, 6'h0b, 1, 0, 0, 2, ST_HALT, 1, 1, 0});
        tbl.push_back('{"badfn",  6'h00, 6'h3f, 0, 0, 0, 2, ST_HALT, 1, 1, 0});
        tbl.push_back('{"if_to",  6'h00, 6'h20, 0, 4, 0, 4, ST_ERR,  1, 0, 1});
        tbl.push_back('{"lw_to",  6'h23, 6'h00, 0, 0, 5, 7, ST_ERR,  1, 0, 1});
        tbl.push_back('{"sw_to",  6'h2b, 6'h00, 0, 1, 4, 8, ST_ERR,  1, 0, 1});

        foreach (tbl[i]) begin
            run_instr(tbl[i].op, tbl[i].func, tbl[i].z, tbl[i].ifw, tbl[i].memw, dc, tm);
            chk({tbl[i].name, "_cycles"}, 32'(dc), 32'(tbl[i].cyc));
            chk({tbl[i].name, "_halted"}, 32'(halted), 32'(tbl[i].hl));
            chk({tbl[i].name, "_illegal"}, 32'(illegal), 32'(tbl[i].il));
            chk({tbl[i].name, "_bus_err"}, 32'(bus_err), 32'(tbl[i].be));
            if (state_o != 3'(ST_IF) || tbl[i].term != ST_IF) do_reset();
        end

        pool = '{{6'h00, 6'h20}, {6'h00, 6'h22}, {6'h00, 6'h2a}, {6'h00, 6'h24}, {6'h00, 6'h25},
                 {6'h00, 6'h00}, {6'h00, 6'h08}, {6'h08, 6'h00}, {6'h0d, 6'h00}, {6'h23, 6'h00},
                 {6'h2b, 6'h00}, {6'h04, 6'h00}, {6'h02, 6'h00}, {6'h03, 6'h00}, {6'h3f, 6'h00},
                 {6'h30, 6'h00}, {6'h00, 6'h0a}, {6'h00, 6'h0b}};
        for (int r = 0; r < 80; r++) begin
            logic [11:0] pk;
            logic [5:0] rop, rfn;
            int ifw, memw;
            pk  = pool[$urandom_range(17, 0)];
            rop = pk[11:6];
            rfn = (rop == 6'h00) ? pk[5:0] : 6'($urandom);
            ifw  = ($urandom_range(7, 0) == 0) ? $urandom_range(TO + 1, TO) : $urandom_range(TO - 1, 0);
            memw = ($urandom_range(7, 0) == 0) ? $urandom_range(TO + 1, TO) : $urandom_range(TO - 1, 0);
            run_instr(rop, rfn, 1'($urandom), ifw, memw, dc, tm);
            chk("rand_cycles", 32'(dc), 32'(seq.size()));
            if (state_o != 3'(ST_IF) || tm != ST_IF) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mc_ctrl_unit_hs.md
Name: mc_ctrl_unit_hs

Overview:
Parametrised successor to the multicycle CPU control unit. Sequences IF/ID/EX/MEM/WB per instruction, with a req/ready handshake to a variable-latency memory, a wait-state timeout, a halt instruction, and illegal-opcode trapping. Sits between the instruction register/decoder fields and the datapath muxes, RF, ALU and memory port.

Parameters:
ALUOP_W, 4, width of op_ALU.
MEM_TIMEOUT, 15, max consecutive mem_ready-low cycles in IF/MEM before error; 0 disables timeout.
HALT_OP, 6'b111111, opcode of the halt instruction.

Ports:
CLK  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high.
op_instruction  in  6  IR op field.
func_instruction  in  6  IR func field.
zero  in  1  ALU zero flag.
mem_ready  in  1  memory completes the current access this cycle.
mem_req  out  1  memory access request.
mem_we  out  1  1=write (sw), 0=read.
ir_we  out  1  latch fetched word into IR.
w_pc  out  1  PC write.
slc_ALUA  out  1  0=PC, 1=rs.
slc_ALUB  out  1  0=rt, 1=extended imm.
slc_RFWriteData  out  2  00 ALU, 01 memory, 10 rs (movn/movz).
w_RF  out  1  RF write.
op_ext  out  2  00 sa zero-ext, 01 zero-ext, 10 sign-ext.
slc_pcSrc  out  2  00 PC+4, 01 branch, 10 rs, 11 jump target.
slc_RFWriteAddr  out  2  00 $31, 01 rt, 10 rd.
op_ALU  out  ALUOP_W  ALU op.
halted  out  1  sticky; halt executed or illegal opcode.
illegal  out  1  sticky; illegal opcode decoded.
bus_err  out  1  sticky; memory timeout.
state_o  out  3  current state, for debug.

Behaviour:
- Only the state register, wait counter and sticky flags are registered; all control outputs decode combinationally from the state register and IR fields (Moore plus IR decode).
- States: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5, ERR=6.
- Reset (async): state=IF, wait counter=0, halted/illegal/bus_err=0. Outputs in IF with mem_ready=0: all 0 except mem_req=1.
- Default value of every output in every state is 0 unless listed below.
- IF: mem_req=1, mem_we=0. ir_we=mem_ready. On mem_ready go to ID, else stay.
- ID: op_ext=00 for sll, 10 for lw/sw/addi/beq, 01 for ori. HALT_OP goes to HALT with halted=1. Undefined op/func goes to HALT with halted=1 and illegal=1. All other instructions go to EX.
- EX: op_ext held. ALU ops: add/addi/lw/sw 0000, sub/beq 0001, slt 0010, sll 0100, or/ori 0101, and 0110, movn/movz 1000, jal 1001, zero-extended to ALUOP_W. slc_ALUA=1 except jal (0). slc_ALUB=1 for imm/sll/lw/sw, else 0. Transitions:
  - j: w_pc=1, pcSrc=11, go to IF.
  - jr: w_pc=1, pcSrc=10, go to IF.
  - beq: w_pc=1, pcSrc = zero ? 01 : 00, go to IF.
  - lw/sw: go to MEM.
  - all others: go to WB.
- MEM: ALU controls held. mem_req=1, mem_we=(op==sw). On mem_ready: sw sets w_pc=1 and goes to IF; lw goes to WB.
- WB:
  - w_pc=1; pcSrc=11 for jal, else 00.
  - slc_RFWriteData: 01 for lw, 10 for movn/movz, else 00.
  - slc_RFWriteAddr: 00 for jal, 01 for addi/ori/lw, 10 for op=0.
  - w_RF=1, except movn with zero=1 or movz with zero=0 (w_RF=0).
  - Go to IF.
- Latency with mem_ready tied high: beq/j/jr 3 cycles; R-type/imm/jal/sw 4; lw 5.
- Wait counter: increments each IF/MEM cycle with mem_ready=0; clears on mem_ready or on leaving IF/MEM. When the counter reaches MEM_TIMEOUT with mem_ready still 0, go to ERR and set bus_err=1 and halted=1.
- mem_ready in the same cycle the counter hits the limit: the access completes and no error is raised.
- HALT/ERR: all strobes 0, mem_req=0. Left only by reset.
- Reset mid-access drops mem_req immediately (combinational).

Optional Feature:
MOVCOND_EN: when defined, movn/movz are decoded as above. When undefined, func 001010/001011 are illegal: HALT with illegal=1, and no RF write occurs.

Test Plan:
- add, mem_ready=1 -> states IF,ID,EX,WB, then IF; WB: w_RF=1, slc_RFWriteAddr=10, w_pc=1, op_ALU=0000.
- lw, mem_ready low 3 cycles in MEM -> mem_req=1 held for 4 MEM cycles; WB: slc_RFWriteData=01, slc_RFWriteAddr=01; 8 cycles total.
- beq with zero=1, then zero=0 -> EX: w_pc=1 with pcSrc=01, then 00; no WB visit.
- MEM_TIMEOUT=4, mem_ready stuck 0 in IF -> ERR after 4 wait cycles; bus_err=halted=1; mem_req=0 until reset.
- op=6'b111111 -> HALT after ID; halted=1, illegal=0. Op 6'b110000 -> halted=1, illegal=1.
- movz with zero=0 -> w_RF=0 in WB (MOVCOND_EN defined). Without the macro -> illegal=1.
